// File: rtl/ata_device.sv
// ATA PIO disk responder: task-file decode plus IDENTIFY / READ SECTORS / WRITE SECTORS
// through a 256-word sector buffer backed by an external word-addressed memory.
module ata_device #(
    parameter logic [31:0] CAPACITY   = 32'd16384,
    parameter logic [15:0] RESET_BUSY = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ata_d_in,
    output logic [15:0] ata_d_out,
    output logic        ata_d_oe,
    input  logic [2:0]  ata_a,
    input  logic        ata_cs0_n,
    input  logic        ata_cs1_n,
    input  logic        ata_dior_n,
    input  logic        ata_diow_n,
    output logic        ata_intrq,
    output logic        ata_iordy,
    output logic [27:0] mem_sector,
    output logic [7:0]  mem_word,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [2:0] {S_POR, S_IDLE, S_IDENT, S_FILL, S_XOUT, S_XIN, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [8:0]  ptr_q, ptr_d, rem_q, rem_d, rem_new;
    logic [27:0] lba_q, lba_d;
    logic [7:0]  err_reg_q, err_reg_d;
    logic        err_q, err_d, irq_q, irq_d, nien_q, nien_d;
    logic        intrq_q, intrq_d, oe_q, oe_d;
    logic [15:0] dout_q, dout_d, rd_data, status, wdat_q;
    logic [2:0]  a_q;
    logic        cs0_q, cs1_q, dior_q, diow_q, dior_prev_q, diow_prev_q;
    logic        sel_cmd, sel_ctl, rd_rise, wr_rise, bsy, drq, srst;
    logic        buf_we;
    logic [7:0]  buf_waddr;
    logic [15:0] buf_wdata;
    logic [15:0] sbuf_q [256];

    assign sel_cmd = !cs0_q && cs1_q;
    assign sel_ctl = cs0_q && !cs1_q && (a_q == 3'd6);
    assign rd_rise = dior_q && !dior_prev_q;
    assign wr_rise = diow_q && !diow_prev_q;
    assign srst    = wr_rise && sel_ctl && wdat_q[2];
    assign bsy     = (state_q == S_POR) || (state_q == S_IDENT) || (state_q == S_FILL) || (state_q == S_FLUSH);
    assign drq     = (state_q == S_XOUT) || (state_q == S_XIN);
    assign status  = {8'h00, bsy, state_q != S_POR, 2'b00, drq, 2'b00, err_q};
    assign rem_new = (rem_q[7:0] == 8'd0) ? 9'd256 : {1'b0, rem_q[7:0]};

    assign ata_d_out  = dout_q;
    assign ata_d_oe   = oe_q;
    assign ata_intrq  = intrq_q;
    assign ata_iordy  = 1'b1;
    assign mem_rd     = (state_q == S_FILL) && !cnt_q[8];
    assign mem_wr     = (state_q == S_FLUSH);
    assign mem_word   = (state_q == S_FILL || state_q == S_FLUSH) ? cnt_q[7:0] : 8'd0;
    assign mem_sector = (state_q == S_FILL || state_q == S_FLUSH) ? lba_q : 28'd0;
    assign mem_wdata  = (state_q == S_FLUSH) ? sbuf_q[cnt_q[7:0]] : 16'd0;

    always_comb begin
        rd_data = 16'd0;
        if (sel_ctl) begin
            rd_data = status;
        end else if (sel_cmd) begin
            unique case (a_q)
                3'd0: rd_data = drq ? sbuf_q[ptr_q[7:0]] : 16'd0;
                3'd1: rd_data = {8'h00, err_reg_q};
                3'd2: rd_data = {8'h00, rem_q[7:0]};
                3'd3: rd_data = {8'h00, lba_q[7:0]};
                3'd4: rd_data = {8'h00, lba_q[15:8]};
                3'd5: rd_data = {8'h00, lba_q[23:16]};
                3'd6: rd_data = {12'h000, lba_q[27:24]};
                default: rd_data = status;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  ptr_d = ptr_q;  rem_d = rem_q;
        lba_d = lba_q;  err_d = err_q;  err_reg_d = err_reg_q;
        irq_d = irq_q;  nien_d = nien_q;
        buf_we = 1'b0;  buf_waddr = cnt_q[7:0];  buf_wdata = 16'd0;

        // Status-read clear comes first so that an interrupt raised in the same cycle wins.
        if (rd_rise && sel_cmd && a_q == 3'd7) irq_d = 1'b0;

        unique case (state_q)
            S_POR: begin
                if (cnt_q == RESET_BUSY - 16'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IDENT: begin
                buf_we = 1'b1;
                if (cnt_q[7:0] == 8'd0)       buf_wdata = 16'h0040;
                else if (cnt_q[7:0] == 8'd60) buf_wdata = CAPACITY[15:0];
                else if (cnt_q[7:0] == 8'd61) buf_wdata = CAPACITY[31:16];
                if (cnt_q[7:0] == 8'd255) begin
                    state_d = S_XOUT;  cnt_d = 16'd0;  ptr_d = 9'd0;  irq_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FILL: begin
                // mem_rdata lags mem_rd by one cycle, so buffer writes trail the word counter.
                buf_we    = (cnt_q != 16'd0);
                buf_waddr = cnt_q[7:0] - 8'd1;
                buf_wdata = mem_rdata;
                if (cnt_q == 16'd256) begin
                    state_d = S_XOUT;  cnt_d = 16'd0;  ptr_d = 9'd0;  irq_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_XOUT: begin
                if (rd_rise && sel_cmd && a_q == 3'd0) begin
                    ptr_d = ptr_q + 9'd1;
                    if (ptr_q == 9'd255) begin
                        ptr_d = 9'd0;
                        if (rem_q == 9'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            rem_d = rem_q - 9'd1;  lba_d = lba_q + 28'd1;
                            cnt_d = 16'd0;         state_d = S_FILL;
                        end
                    end
                end
            end
            S_XIN: begin
                if (wr_rise && sel_cmd && a_q == 3'd0) begin
                    buf_we = 1'b1;  buf_waddr = ptr_q[7:0];  buf_wdata = wdat_q;
                    ptr_d  = ptr_q + 9'd1;
                    if (ptr_q == 9'd255) begin
                        ptr_d = 9'd0;  cnt_d = 16'd0;  state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q[7:0] == 8'd255) begin
                    irq_d = 1'b1;  cnt_d = 16'd0;  ptr_d = 9'd0;
                    if (rem_q == 9'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_q - 9'd1;  lba_d = lba_q + 28'd1;  state_d = S_XIN;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_rise && sel_cmd && !bsy) begin
            unique case (a_q)
                3'd2: rem_d = {1'b0, wdat_q[7:0]};
                3'd3: lba_d[7:0]   = wdat_q[7:0];
                3'd4: lba_d[15:8]  = wdat_q[7:0];
                3'd5: lba_d[23:16] = wdat_q[7:0];
                3'd6: lba_d[27:24] = wdat_q[3:0];
                3'd7: begin
                    if (state_q == S_IDLE) begin
                        err_d = 1'b0;  err_reg_d = 8'h00;  cnt_d = 16'd0;  ptr_d = 9'd0;
                        unique case (wdat_q[7:0])
                            8'hEC: begin
                                rem_d = 9'd1;  state_d = S_IDENT;
                            end
                            8'h20, 8'h30: begin
                                if (({4'h0, lba_q} + {23'd0, rem_new}) > CAPACITY) begin
                                    err_d = 1'b1;  err_reg_d = 8'h10;  irq_d = 1'b1;
                                end else begin
                                    rem_d   = rem_new;
                                    state_d = (wdat_q[7:0] == 8'h20) ? S_FILL : S_XIN;
                                end
                            end
                            default: begin
                                err_d = 1'b1;  err_reg_d = 8'h04;  irq_d = 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end

        if (wr_rise && sel_ctl) nien_d = wdat_q[1];
        if (srst) begin
            state_d = S_POR;  cnt_d = 16'd0;  ptr_d = 9'd0;  rem_d = 9'd0;  lba_d = 28'd0;
            err_d = 1'b0;  err_reg_d = 8'h00;  irq_d = 1'b0;  nien_d = 1'b0;  buf_we = 1'b0;
        end

        oe_d    = !dior_q && (sel_cmd || sel_ctl) && !srst;
        dout_d  = oe_d ? rd_data : 16'd0;
        intrq_d = irq_d && !nien_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_POR;  cnt_q <= 16'd0;  ptr_q <= 9'd0;  rem_q <= 9'd0;
            lba_q <= 28'd0;  err_q <= 1'b0;  err_reg_q <= 8'h00;  irq_q <= 1'b0;
            nien_q <= 1'b0;  intrq_q <= 1'b0;  oe_q <= 1'b0;  dout_q <= 16'd0;
            a_q <= 3'd0;  cs0_q <= 1'b1;  cs1_q <= 1'b1;
            dior_q <= 1'b1;  diow_q <= 1'b1;  dior_prev_q <= 1'b1;  diow_prev_q <= 1'b1;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  ptr_q <= ptr_d;  rem_q <= rem_d;
            lba_q <= lba_d;  err_q <= err_d;  err_reg_q <= err_reg_d;  irq_q <= irq_d;
            nien_q <= nien_d;  intrq_q <= intrq_d;  oe_q <= oe_d;  dout_q <= dout_d;
            a_q <= ata_a;  cs0_q <= ata_cs0_n;  cs1_q <= ata_cs1_n;
            dior_q <= ata_dior_n;  diow_q <= ata_diow_n;
            dior_prev_q <= dior_q;  diow_prev_q <= diow_q;
        end
    end

    // Write data is captured while the strobe is low, so it is still intact when the rising edge is seen.
    always_ff @(posedge clk) begin
        if (!ata_diow_n) wdat_q <= ata_d_in;
        if (buf_we) sbuf_q[buf_waddr] <= buf_wdata;
    end
endmodule

// File: tb/tb_ata_device.sv
// Directed bench for ata_device: host PIO accesses, memory model and transfer monitor.
module tb_ata_device;
    localparam logic [15:0] RB = 16'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ata_d_in = 16'd0;
    logic [15:0] ata_d_out;
    logic        ata_d_oe;
    logic [2:0]  ata_a = 3'd0;
    logic        ata_cs0_n = 1'b1;
    logic        ata_cs1_n = 1'b1;
    logic        ata_dior_n = 1'b1;
    logic        ata_diow_n = 1'b1;
    logic        ata_intrq;
    logic        ata_iordy;
    logic [27:0] mem_sector;
    logic [7:0]  mem_word;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_bad = 0;
    int nsec = 0;
    logic [27:0] sec_log [4];
    logic [15:0] mem_arr [256];
    logic        last_oe;

    ata_device #(.CAPACITY(32'd16384), .RESET_BUSY(RB)) dut (
        .clk(clk), .reset(reset), .ata_d_in(ata_d_in), .ata_d_out(ata_d_out),
        .ata_d_oe(ata_d_oe), .ata_a(ata_a), .ata_cs0_n(ata_cs0_n), .ata_cs1_n(ata_cs1_n),
        .ata_dior_n(ata_dior_n), .ata_diow_n(ata_diow_n), .ata_intrq(ata_intrq),
        .ata_iordy(ata_iordy), .mem_sector(mem_sector), .mem_word(mem_word),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_arr[mem_word];
        if (mem_rd) begin
            rd_cnt++;
            if (mem_word == 8'd0 && nsec < 4) begin
                sec_log[nsec] = mem_sector;
                nsec++;
            end
        end
        if (mem_wr) begin
            if (mem_sector !== 28'd7 || mem_word !== wr_cnt[7:0] || mem_wdata !== (16'hA500 + 16'(wr_cnt)))
                wr_bad++;
            wr_cnt++;
        end
    end

    // Host accesses start and end on a falling clock edge.
    task automatic bus_rd(input logic c0, input logic c1, input logic [2:0] a, output logic [15:0] d);
        ata_a = a;  ata_cs0_n = c0;  ata_cs1_n = c1;  ata_dior_n = 1'b0;
        repeat (3) @(negedge clk);
        d = ata_d_out;
        last_oe = ata_d_oe;
        ata_dior_n = 1'b1;
        repeat (2) @(negedge clk);
        ata_cs0_n = 1'b1;  ata_cs1_n = 1'b1;
    endtask

    task automatic bus_wr(input logic c0, input logic c1, input logic [2:0] a, input logic [15:0] d);
        ata_a = a;  ata_cs0_n = c0;  ata_cs1_n = c1;  ata_d_in = d;  ata_diow_n = 1'b0;
        repeat (3) @(negedge clk);
        ata_diow_n = 1'b1;
        repeat (2) @(negedge clk);
        ata_cs0_n = 1'b1;  ata_cs1_n = 1'b1;
    endtask

    task automatic wait_intrq(input string name);
        for (int i = 0; i < 2000 && ata_intrq !== 1'b1; i++) @(negedge clk);
        n_vec++;
        if (ata_intrq !== 1'b1) begin
            n_err++;
            $display("FAIL %s: intrq got %b want 1 (timeout)", name, ata_intrq);
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (ata_d_oe !== 1'b0 || ata_d_out !== 16'd0) begin
            n_err++; $display("FAIL reset_bus: oe %b out %h want 0 0000", ata_d_oe, ata_d_out);
        end
        n_vec++;
        if (ata_intrq !== 1'b0 || ata_iordy !== 1'b1) begin
            n_err++; $display("FAIL reset_irq: intrq %b iordy %b want 0 1", ata_intrq, ata_iordy);
        end
        n_vec++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_sector !== 28'd0 || mem_word !== 8'd0 || mem_wdata !== 16'd0) begin
            n_err++; $display("FAIL reset_mem: rd %b wr %b sec %h word %h wdata %h want all 0",
                              mem_rd, mem_wr, mem_sector, mem_word, mem_wdata);
        end
        bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0080) begin n_err++; $display("FAIL por_early: altstat %h want 0080", d); end
        repeat (RB - 16'd25) @(negedge clk);
        bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0080) begin n_err++; $display("FAIL por_late: altstat %h want 0080", d); end
        repeat (20) @(negedge clk);
        bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0040) begin n_err++; $display("FAIL por_done: altstat %h want 0040", d); end
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL por_intrq: got %b want 0", ata_intrq); end
    endtask

    task automatic test_identify();
        logic [15:0] d, exp;
        bus_wr(1'b0, 1'b1, 3'd6, 16'h00E0);
        bus_wr(1'b0, 1'b1, 3'd7, 16'h00EC);
        wait_intrq("ident_irq");
        bus_rd(1'b0, 1'b1, 3'd7, d);
        n_vec++;
        if (d !== 16'h0048) begin n_err++; $display("FAIL ident_status: got %h want 0048", d); end
        n_vec++;
        if (last_oe !== 1'b1) begin n_err++; $display("FAIL ident_oe: got %b want 1", last_oe); end
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL ident_irq_clr: got %b want 0", ata_intrq); end
        for (int i = 0; i < 256; i++) begin
            bus_rd(1'b0, 1'b1, 3'd0, d);
            exp = (i == 0) ? 16'h0040 : (i == 60) ? 16'h4000 : 16'h0000;
            n_vec++;
            if (d !== exp) begin n_err++; $display("FAIL ident_word%0d: got %h want %h", i, d, exp); end
        end
        bus_rd(1'b0, 1'b1, 3'd7, d);
        n_vec++;
        if (d !== 16'h0040) begin n_err++; $display("FAIL ident_end: status %h want 0040", d); end
    endtask

    task automatic test_read_sectors();
        logic [15:0] d;
        rd_cnt = 0;  nsec = 0;
        bus_wr(1'b0, 1'b1, 3'd2, 16'd2);
        bus_wr(1'b0, 1'b1, 3'd3, 16'd5);
        bus_wr(1'b0, 1'b1, 3'd4, 16'd0);
        bus_wr(1'b0, 1'b1, 3'd5, 16'd0);
        bus_wr(1'b0, 1'b1, 3'd6, 16'h00E0);
        bus_wr(1'b0, 1'b1, 3'd7, 16'h0020);
        for (int s = 0; s < 2; s++) begin
            wait_intrq("read_irq");
            bus_rd(1'b0, 1'b1, 3'd7, d);
            n_vec++;
            if (d !== 16'h0048) begin n_err++; $display("FAIL read_status%0d: got %h want 0048", s, d); end
            for (int i = 0; i < 256; i++) begin
                bus_rd(1'b0, 1'b1, 3'd0, d);
                n_vec++;
                if (d !== 16'h1000 + 16'(i)) begin
                    n_err++; $display("FAIL read_s%0d_w%0d: got %h want %h", s, i, d, 16'h1000 + 16'(i));
                end
            end
        end
        bus_rd(1'b0, 1'b1, 3'd7, d);
        n_vec++;
        if (d !== 16'h0040) begin n_err++; $display("FAIL read_end: status %h want 0040", d); end
        n_vec++;
        if (nsec !== 2 || sec_log[0] !== 28'd5 || sec_log[1] !== 28'd6) begin
            n_err++; $display("FAIL read_sectors: n %0d first %0d second %0d want 2 5 6", nsec, sec_log[0], sec_log[1]);
        end
        n_vec++;
        if (rd_cnt !== 512) begin n_err++; $display("FAIL read_memrd: got %0d want 512", rd_cnt); end
    endtask

    task automatic test_write_sectors();
        logic [15:0] d;
        wr_cnt = 0;  wr_bad = 0;
        bus_wr(1'b0, 1'b1, 3'd2, 16'd1);
        bus_wr(1'b0, 1'b1, 3'd3, 16'd7);
        bus_wr(1'b0, 1'b1, 3'd7, 16'h0030);
        bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0048) begin n_err++; $display("FAIL write_drq: altstat %h want 0048", d); end
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL write_noirq: got %b want 0", ata_intrq); end
        for (int i = 0; i < 256; i++) bus_wr(1'b0, 1'b1, 3'd0, 16'hA500 + 16'(i));
        wait_intrq("write_irq");
        n_vec++;
        if (wr_cnt !== 256) begin n_err++; $display("FAIL write_count: got %0d want 256", wr_cnt); end
        n_vec++;
        if (wr_bad !== 0) begin n_err++; $display("FAIL write_data: %0d bad writes want 0", wr_bad); end
        bus_rd(1'b0, 1'b1, 3'd7, d);
        n_vec++;
        if (d !== 16'h0040) begin n_err++; $display("FAIL write_end: status %h want 0040", d); end
    endtask

    task automatic test_errors();
        logic [15:0] d;
        int rd0;
        rd0 = rd_cnt;
        bus_wr(1'b0, 1'b1, 3'd2, 16'd1);
        bus_wr(1'b0, 1'b1, 3'd3, 16'h0000);
        bus_wr(1'b0, 1'b1, 3'd4, 16'h0040);
        bus_wr(1'b0, 1'b1, 3'd7, 16'h0020);
        n_vec++;
        if (ata_intrq !== 1'b1) begin n_err++; $display("FAIL idnf_irq: got %b want 1", ata_intrq); end
        bus_rd(1'b0, 1'b1, 3'd7, d);
        n_vec++;
        if (d !== 16'h0041) begin n_err++; $display("FAIL idnf_status: got %h want 0041", d); end
        bus_rd(1'b0, 1'b1, 3'd1, d);
        n_vec++;
        if (d !== 16'h0010) begin n_err++; $display("FAIL idnf_error: got %h want 0010", d); end
        n_vec++;
        if (rd_cnt !== rd0) begin n_err++; $display("FAIL idnf_nomem: %0d reads want 0", rd_cnt - rd0); end
        bus_wr(1'b0, 1'b1, 3'd2, 16'd2);
        bus_wr(1'b0, 1'b1, 3'd3, 16'h00FF);
        bus_wr(1'b0, 1'b1, 3'd4, 16'h003F);
        bus_wr(1'b0, 1'b1, 3'd7, 16'h0020);
        bus_rd(1'b0, 1'b1, 3'd1, d);
        n_vec++;
        if (d !== 16'h0010) begin n_err++; $display("FAIL idnf_edge: error %h want 0010", d); end
        bus_rd(1'b0, 1'b1, 3'd4, d);
        n_vec++;
        if (d !== 16'h003F) begin n_err++; $display("FAIL lba1_readback: got %h want 003F", d); end
        bus_rd(1'b0, 1'b1, 3'd2, d);
        n_vec++;
        if (d !== 16'h0002) begin n_err++; $display("FAIL count_readback: got %h want 0002", d); end
        bus_wr(1'b0, 1'b1, 3'd7, 16'h0091);
        bus_rd(1'b0, 1'b1, 3'd1, d);
        n_vec++;
        if (d !== 16'h0004) begin n_err++; $display("FAIL abrt_error: got %h want 0004", d); end
        bus_rd(1'b0, 1'b1, 3'd7, d);
        n_vec++;
        if (d !== 16'h0041) begin n_err++; $display("FAIL abrt_status: got %h want 0041", d); end
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL abrt_irq_clr: got %b want 0", ata_intrq); end
    endtask

    task automatic test_nien_srst();
        logic [15:0] d;
        bus_wr(1'b1, 1'b0, 3'd6, 16'h0002);
        bus_wr(1'b0, 1'b1, 3'd2, 16'd1);
        bus_wr(1'b0, 1'b1, 3'd3, 16'd3);
        bus_wr(1'b0, 1'b1, 3'd4, 16'd0);
        bus_wr(1'b0, 1'b1, 3'd7, 16'h0020);
        d = 16'd0;
        for (int i = 0; i < 100 && d !== 16'h0048; i++) bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0048) begin n_err++; $display("FAIL nien_drq: altstat %h want 0048", d); end
        for (int i = 0; i < 3; i++) begin
            bus_rd(1'b0, 1'b1, 3'd0, d);
            n_vec++;
            if (d !== 16'h1000 + 16'(i)) begin n_err++; $display("FAIL nien_word%0d: got %h want %h", i, d, 16'h1000 + 16'(i)); end
        end
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL nien_mask: got %b want 0", ata_intrq); end
        bus_wr(1'b1, 1'b0, 3'd6, 16'h0004);
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL srst_irq: got %b want 0", ata_intrq); end
        bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0080) begin n_err++; $display("FAIL srst_busy: altstat %h want 0080", d); end
        bus_rd(1'b0, 1'b1, 3'd0, d);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL srst_data: got %h want 0000", d); end
        bus_rd(1'b0, 1'b1, 3'd3, d);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL srst_lba0: got %h want 0000", d); end
        bus_rd(1'b0, 1'b1, 3'd2, d);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL srst_count: got %h want 0000", d); end
        repeat (RB + 16'd10) @(negedge clk);
        bus_rd(1'b1, 1'b0, 3'd6, d);
        n_vec++;
        if (d !== 16'h0040) begin n_err++; $display("FAIL srst_por_done: altstat %h want 0040", d); end
        n_vec++;
        if (ata_intrq !== 1'b0) begin n_err++; $display("FAIL srst_final_irq: got %b want 0", ata_intrq); end
    endtask

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'h1000 + 16'(i);
        @(negedge clk);
        test_reset();
        test_identify();
        test_read_sectors();
        test_write_sectors();
        test_errors();
        test_nien_srst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
